// File: rtl/cfg_stream_writer_pkg.sv
// Shared constants for the configuration stream writer: module selects,
// header field layout, error codes and FSM state encoding.
package cfg_pkg;

  localparam logic [1:0] MOD_IBF_NET = 2'd0;
  localparam logic [1:0] MOD_IBF_MUX = 2'd1;
  localparam logic [1:0] MOD_BV      = 2'd2;
  localparam logic [1:0] MOD_BF      = 2'd3;

  localparam int HDR_MOD_LSB  = 0;
  localparam int HDR_MOD_W    = 2;
  localparam int HDR_SRAM_LSB = 2;
  localparam int HDR_SRAM_W   = 8;
  localparam int HDR_ADDR_LSB = 10;
  localparam int HDR_ADDR_W   = 7;
  localparam int HDR_CNT_LSB  = 17;
  localparam int HDR_CNT_W    = 8;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_ADDR_OVF   = 2'd1,
    ERR_EARLY_LAST = 2'd2,
    ERR_MISS_LAST  = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/cfg_stream_writer_if.sv
// Host word stream (valid/ready) plus the outgoing config write bus.
// master = host loader side, slave = the writer.
interface cfg_stream_writer_if #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 7,
  parameter int SRAM_SEL_W = 8,
  parameter int SEL_W      = 2
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_W-1:0]     s_data;
  logic                  s_last;
  logic [SEL_W-1:0]      cfg_sel_module;
  logic [SRAM_SEL_W-1:0] cfg_sram_sel;
  logic [ADDR_W-1:0]     cfg_addr_write;
  logic                  cfg_wr_en;
  logic [DATA_W-1:0]     cfg_data;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  cfg_sel_module, cfg_sram_sel, cfg_addr_write, cfg_wr_en, cfg_data
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready,
    output cfg_sel_module, cfg_sram_sel, cfg_addr_write, cfg_wr_en, cfg_data
  );
endinterface

// File: rtl/cfg_stream_writer_depth_check.sv
// Per-module SRAM depth lookup; flags whether an address falls inside the
// target module's SRAM.
module cfg_depth_check
  import cfg_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int ADDR_W   = 7,
  parameter int DEPTH_M0 = 3,
  parameter int DEPTH_M1 = 4,
  parameter int DEPTH_M2 = 64,
  parameter int DEPTH_M3 = 96
) (
  input  logic [SEL_W-1:0]  mod,
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  logic [31:0] depth;

  // Select depth of the addressed module and compare.
  always_comb begin
    depth = 32'(DEPTH_M0);
    case (mod)
      MOD_IBF_NET: depth = 32'(DEPTH_M0);
      MOD_IBF_MUX: depth = 32'(DEPTH_M1);
      MOD_BV:      depth = 32'(DEPTH_M2);
      MOD_BF:      depth = 32'(DEPTH_M3);
      default:     depth = 32'(DEPTH_M0);
    endcase
    in_range = 32'(addr) < depth;
  end

endmodule

// File: rtl/cfg_stream_writer.sv
// Config write initiator: turns header+payload packets from the host loader
// into registered config writes with auto-incrementing addresses, depth
// checking and framing checks reported through sticky error status.
//
// state    | meaning
// ST_IDLE  | waiting for a header word
// ST_DATA  | issuing one write per accepted payload word
// ST_DRAIN | discarding words until s_last after a framing error
module cfg_stream_writer
  import cfg_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 7,
  parameter int SRAM_SEL_W = 8,
  parameter int SEL_W      = 2,
  parameter int DEPTH_M0   = 3,
  parameter int DEPTH_M1   = 4,
  parameter int DEPTH_M2   = 64,
  parameter int DEPTH_M3   = 96
) (
  input  logic                clk,
  input  logic                rst_n,
  cfg_stream_writer_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  input  logic                err_clr
);

  localparam logic [HDR_CNT_W-1:0] CNT_ONE = HDR_CNT_W'(1);

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       mod_q;
  logic [SRAM_SEL_W-1:0]  sram_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [HDR_CNT_W-1:0]   rem_q;
  logic                   rdy_q;
  logic                   acc;
  logic                   in_range;
  logic                   done_d;
  logic                   err_set;
  err_code_t              err_new;

  logic [SEL_W-1:0]       hdr_mod;
  logic [SRAM_SEL_W-1:0]  hdr_sram;
  logic [ADDR_W-1:0]      hdr_addr;
  logic [HDR_CNT_W-1:0]   hdr_cnt;

  assign acc      = bus.s_valid & bus.s_ready;
  assign hdr_mod  = bus.s_data[HDR_MOD_LSB  +: HDR_MOD_W];
  assign hdr_sram = bus.s_data[HDR_SRAM_LSB +: HDR_SRAM_W];
  assign hdr_addr = bus.s_data[HDR_ADDR_LSB +: HDR_ADDR_W];
  assign hdr_cnt  = bus.s_data[HDR_CNT_LSB  +: HDR_CNT_W];

  cfg_depth_check #(
    .SEL_W    (SEL_W),
    .ADDR_W   (ADDR_W),
    .DEPTH_M0 (DEPTH_M0),
    .DEPTH_M1 (DEPTH_M1),
    .DEPTH_M2 (DEPTH_M2),
    .DEPTH_M3 (DEPTH_M3)
  ) u_depth_check (
    .mod      (mod_q),
    .addr     (addr_q),
    .in_range (in_range)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, done and error detection; address overflow takes priority
  // when one word triggers both an overflow and a framing error.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    err_new = ERR_NONE;
    case (state_q)
      ST_IDLE: if (acc) begin
        if (hdr_cnt == '0) begin
          if (bus.s_last) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            err_set = 1'b1;
            err_new = ERR_MISS_LAST;
          end
        end else if (bus.s_last) begin
          err_set = 1'b1;
          err_new = ERR_EARLY_LAST;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: if (acc) begin
        if (!in_range) begin
          err_set = 1'b1;
          err_new = ERR_ADDR_OVF;
        end
        if (rem_q == CNT_ONE) begin
          if (bus.s_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
            if (!err_set) begin
              err_set = 1'b1;
              err_new = ERR_MISS_LAST;
            end
          end
        end else if (bus.s_last) begin
          state_d = ST_IDLE;
          if (!err_set) begin
            err_set = 1'b1;
            err_new = ERR_EARLY_LAST;
          end
        end
      end
      ST_DRAIN: if (acc && bus.s_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs; ready comes from a register so it stays low in reset.
  always_comb begin
    bus.s_ready = rdy_q;
    busy        = (state_q != ST_IDLE);
  end

  // Header latch, address/count tracking and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q              <= 1'b0;
      done               <= 1'b0;
      mod_q              <= '0;
      sram_q             <= '0;
      addr_q             <= '0;
      rem_q              <= '0;
      bus.cfg_wr_en      <= 1'b0;
      bus.cfg_data       <= '0;
      bus.cfg_addr_write <= '0;
      bus.cfg_sel_module <= '0;
      bus.cfg_sram_sel   <= '0;
    end else begin
      rdy_q         <= 1'b1;
      done          <= done_d;
      bus.cfg_wr_en <= 1'b0;
      if (state_q == ST_IDLE && acc) begin
        mod_q  <= hdr_mod;
        sram_q <= hdr_sram;
        addr_q <= hdr_addr;
        rem_q  <= hdr_cnt;
      end
      if (state_q == ST_DATA && acc) begin
        bus.cfg_wr_en      <= in_range;
        bus.cfg_data       <= bus.s_data;
        bus.cfg_addr_write <= addr_q;
        bus.cfg_sel_module <= mod_q;
        bus.cfg_sram_sel   <= sram_q;
        addr_q             <= addr_q + ADDR_W'(1);
        rem_q              <= rem_q - CNT_ONE;
      end
    end
  end

  // Sticky error: keep the first code; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= 2'd0;
    end else if (err_set && (!err || err_clr)) begin
      err      <= 1'b1;
      err_code <= err_new;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_code <= 2'd0;
    end
  end

endmodule

// File: tb/tb_cfg_stream_writer.sv
// Directed bench for cfg_stream_writer: packet framing, depth checks,
// stalls, reset and sticky error behaviour.
module tb_cfg_stream_writer;
  import cfg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       err_clr;
  logic       busy, done, err;
  logic [1:0] err_code;
  int         n_checks = 0;
  int         n_fail = 0;

  cfg_stream_writer_if bus_if ();

  cfg_stream_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] hdr(input int m, input int s, input int a, input int c);
    logic [63:0] h;
    h = 64'hABCD_0000_0000_0000;
    h[1:0]   = m[1:0];
    h[9:2]   = s[7:0];
    h[16:10] = a[6:0];
    h[24:17] = c[7:0];
    return h;
  endfunction

  task automatic send(input logic [63:0] d, input logic last);
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = d;
    bus_if.s_last  = last;
    @(posedge clk);
    #1;
    bus_if.s_valid = 1'b0;
    bus_if.s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b0 || bus_if.cfg_addr_write !== 7'd0 || bus_if.cfg_data !== 64'd0 ||
        bus_if.cfg_sel_module !== 2'd0 || bus_if.cfg_sram_sel !== 8'd0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 || bus_if.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs wr_en=%b addr=%0d busy=%b done=%b err=%b code=%0d ready=%b expected all 0",
               bus_if.cfg_wr_en, bus_if.cfg_addr_write, busy, done, err, err_code, bus_if.s_ready);
    end
    rst_n = 1'b1;
    idle(1);
    n_checks++;
    if (bus_if.s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release ready=%b busy=%b expected 1 0", bus_if.s_ready, busy);
    end
  endtask

  task automatic test_basic();
    logic [63:0] d [3];
    d[0] = 64'h1111_2222_3333_4444;
    d[1] = 64'h5555_6666_7777_8888;
    d[2] = 64'h9999_AAAA_BBBB_CCCC;
    send(hdr(3, 5, 10, 3), 1'b0);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_hdr wr_en=%b busy=%b expected 0 1", bus_if.cfg_wr_en, busy);
    end
    for (int i = 0; i < 3; i++) begin
      send(d[i], i == 2);
      n_checks++;
      if (bus_if.cfg_wr_en !== 1'b1 || bus_if.cfg_addr_write !== 7'(10 + i) || bus_if.cfg_data !== d[i] ||
          bus_if.cfg_sel_module !== 2'd3 || bus_if.cfg_sram_sel !== 8'd5 || done !== (i == 2)) begin
        n_fail++;
        $display("FAIL basic_w%0d wr_en=%b addr=%0d data=%h sel=%0d sram=%0d done=%b expected 1 %0d %h 3 5 %b",
                 i, bus_if.cfg_wr_en, bus_if.cfg_addr_write, bus_if.cfg_data, bus_if.cfg_sel_module,
                 bus_if.cfg_sram_sel, done, 10 + i, d[i], i == 2);
      end
    end
    idle(1);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        bus_if.cfg_addr_write !== 7'd12) begin
      n_fail++;
      $display("FAIL basic_end wr_en=%b done=%b busy=%b err=%b addr=%0d expected 0 0 0 0 12",
               bus_if.cfg_wr_en, done, busy, err, bus_if.cfg_addr_write);
    end
  endtask

  task automatic test_overflow();
    logic exp_en [4];
    exp_en = '{1'b1, 1'b1, 1'b0, 1'b0};
    send(hdr(0, 1, 1, 4), 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(64'(100 + i), i == 3);
      n_checks++;
      if (bus_if.cfg_wr_en !== exp_en[i] || done !== (i == 3)) begin
        n_fail++;
        $display("FAIL ovf_w%0d wr_en=%b done=%b expected %b %b", i, bus_if.cfg_wr_en, done, exp_en[i], i == 3);
      end
    end
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd1) begin
      n_fail++;
      $display("FAIL ovf_code err=%b code=%0d expected 1 1", err, err_code);
    end
    clear_err();
    send(hdr(3, 0, 95, 2), 1'b0);
    send(64'd7, 1'b0);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b1 || bus_if.cfg_addr_write !== 7'd95 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL bf_edge95 wr_en=%b addr=%0d err=%b expected 1 95 0", bus_if.cfg_wr_en, bus_if.cfg_addr_write, err);
    end
    send(64'd8, 1'b1);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b0 || err_code !== 2'd1) begin
      n_fail++;
      $display("FAIL bf_edge96 wr_en=%b code=%0d expected 0 1", bus_if.cfg_wr_en, err_code);
    end
    clear_err();
    n_checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL ovf_clear err=%b code=%0d expected 0 0", err, err_code);
    end
  endtask

  task automatic test_early_last();
    send(hdr(2, 0, 0, 5), 1'b0);
    send(64'hA0, 1'b0);
    send(64'hA1, 1'b1);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b1 || bus_if.cfg_addr_write !== 7'd1 || bus_if.cfg_data !== 64'hA1 ||
        done !== 1'b0 || busy !== 1'b0 || err_code !== 2'd2) begin
      n_fail++;
      $display("FAIL early_w1 wr_en=%b addr=%0d done=%b busy=%b code=%0d expected 1 1 0 0 2",
               bus_if.cfg_wr_en, bus_if.cfg_addr_write, done, busy, err_code);
    end
    send(hdr(1, 7, 0, 1), 1'b0);
    send(64'hB0, 1'b1);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b1 || bus_if.cfg_sel_module !== 2'd1 || bus_if.cfg_sram_sel !== 8'd7 ||
        bus_if.cfg_addr_write !== 7'd0 || done !== 1'b1 || err_code !== 2'd2) begin
      n_fail++;
      $display("FAIL early_next wr_en=%b sel=%0d sram=%0d addr=%0d done=%b code=%0d expected 1 1 7 0 1 2",
               bus_if.cfg_wr_en, bus_if.cfg_sel_module, bus_if.cfg_sram_sel, bus_if.cfg_addr_write, done, err_code);
    end
    clear_err();
  endtask

  task automatic test_missing_last();
    send(hdr(2, 3, 20, 2), 1'b0);
    send(64'hC0, 1'b0);
    send(64'hC1, 1'b0);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b1 || bus_if.cfg_addr_write !== 7'd21 || done !== 1'b0 ||
        busy !== 1'b1 || err_code !== 2'd3) begin
      n_fail++;
      $display("FAIL miss_w1 wr_en=%b addr=%0d done=%b busy=%b code=%0d expected 1 21 0 1 3",
               bus_if.cfg_wr_en, bus_if.cfg_addr_write, done, busy, err_code);
    end
    send(64'hC2, 1'b0);
    send(64'hC3, 1'b1);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || bus_if.cfg_data !== 64'hC1) begin
      n_fail++;
      $display("FAIL miss_drain wr_en=%b done=%b busy=%b data=%h expected 0 0 0 c1",
               bus_if.cfg_wr_en, done, busy, bus_if.cfg_data);
    end
    clear_err();
  endtask

  task automatic test_zero_count();
    send(hdr(3, 0, 0, 0), 1'b1);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus_if.cfg_wr_en !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_cnt done=%b busy=%b wr_en=%b err=%b expected 1 0 0 0", done, busy, bus_if.cfg_wr_en, err);
    end
    idle(1);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_cnt_pulse done=%b expected 0", done);
    end
  endtask

  task automatic test_stall_reset();
    send(hdr(3, 2, 40, 4), 1'b0);
    send(64'hD0, 1'b0);
    idle(2);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_idle wr_en=%b busy=%b expected 0 1", bus_if.cfg_wr_en, busy);
    end
    send(64'hD1, 1'b0);
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b1 || bus_if.cfg_addr_write !== 7'd41 || bus_if.cfg_data !== 64'hD1) begin
      n_fail++;
      $display("FAIL stall_resume wr_en=%b addr=%0d data=%h expected 1 41 d1",
               bus_if.cfg_wr_en, bus_if.cfg_addr_write, bus_if.cfg_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_if.cfg_wr_en !== 1'b0 || bus_if.cfg_addr_write !== 7'd0 || bus_if.cfg_data !== 64'd0 ||
        bus_if.cfg_sel_module !== 2'd0 || bus_if.cfg_sram_sel !== 8'd0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || bus_if.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midpkt_reset wr_en=%b addr=%0d data=%h busy=%b ready=%b expected all 0",
               bus_if.cfg_wr_en, bus_if.cfg_addr_write, bus_if.cfg_data, busy, bus_if.s_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send(hdr(1, 0, 0, 0), 1'b1);
    n_checks++;
    if (done !== 1'b1 || bus_if.cfg_wr_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle done=%b wr_en=%b busy=%b expected 1 0 0", done, bus_if.cfg_wr_en, busy);
    end
  endtask

  task automatic test_err_priority();
    send(hdr(0, 0, 0, 3), 1'b1);
    send(hdr(0, 0, 0, 0), 1'b0);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_err_kept err=%b code=%0d busy=%b expected 1 2 1", err, err_code, busy);
    end
    send(64'd0, 1'b1);
    err_clr = 1'b1;
    send(hdr(1, 0, 0, 0), 1'b0);
    err_clr = 1'b0;
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd3) begin
      n_fail++;
      $display("FAIL clr_vs_new err=%b code=%0d expected 1 3", err, err_code);
    end
    send(64'd0, 1'b1);
    clear_err();
    n_checks++;
    if (err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL final_clear err=%b code=%0d busy=%b expected 0 0 0", err, err_code, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    err_clr        = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.s_last  = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_early_last();
    test_missing_last();
    test_zero_count();
    test_stall_reset();
    test_err_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
